// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port synchronous memory between the fetch requester and
// the data requester. Grants at most one requester per cycle, drives the
// memory port, and routes the one-cycle-later read data (or an out-of-range
// error) back to whichever requester was granted. A denied-fetch counter
// lets fetch win after STARVE_MAX consecutive losses to data traffic.

module unified_mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch requester
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // data requester
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_DM   = 2'd2
  } sel_t;

  localparam int          HI_BIT  = ADDR_W + 2;
  localparam logic [3:0]  CNT_MAX = 4'(STARVE_MAX);

  // A byte address is usable only if word-aligned and inside the memory.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[31:HI_BIT] == '0) && (a[1:0] == 2'b00);
  endfunction

  sel_t        resp_sel;
  logic        resp_err;
  logic        resp_we;
  logic [3:0]  starve_cnt;

  logic        fetch_wins;
  logic        grant_if;
  logic        grant_dm;
  logic [31:0] sel_addr;
  logic        sel_ok;
  logic        resp_live;
  logic [DATA_W-1:0] resp_data;

  // Arbitration and memory-port drive: data wins ties unless fetch has starved.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    fetch_wins = (starve_cnt == CNT_MAX);
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    if (!reset) begin
      grant_dm = dm_req && !(if_req && fetch_wins);
      grant_if = if_req && !grant_dm;
    end
    sel_addr  = grant_dm ? dm_addr : if_addr;
    sel_ok    = addr_ok(sel_addr);
    if_ack    = grant_if;
    dm_ack    = grant_dm;
    mem_en    = (grant_if || grant_dm) && sel_ok;
    mem_we    = mem_en && grant_dm && dm_we;
    mem_addr  = sel_addr[ADDR_W+1:2];
    mem_wdata = dm_wdata;
  end

  // Response register and fetch-starvation counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      resp_sel   <= SEL_NONE;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      if (grant_dm)      resp_sel <= SEL_DM;
      else if (grant_if) resp_sel <= SEL_IF;
      else               resp_sel <= SEL_NONE;
      resp_err <= !sel_ok;
      resp_we  <= grant_dm && dm_we;
      if (if_req && !grant_if)
        starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;
    end
  end

  // Response routing: read data only for successful loads/fetches.
  always_comb begin
    // NOTE: outputs are masked while reset is high so a response registered
    // just before reset never produces a valid pulse.
    resp_live = !reset;
    resp_data = (resp_err || resp_we) ? '0 : mem_rdata;
    if_valid  = resp_live && (resp_sel == SEL_IF);
    dm_valid  = resp_live && (resp_sel == SEL_DM);
    if_err    = if_valid && resp_err;
    dm_err    = dm_valid && resp_err;
    if_rdata  = if_valid ? resp_data : '0;
    dm_rdata  = dm_valid ? resp_data : '0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios followed by randomized
// traffic, all compared each cycle against a transaction-level model.

module tb_unified_mem_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_ack, if_valid, if_err;
  logic [31:0]       if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_ack, dm_valid, dm_err;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h2008_0005 : 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Memory attached to the port; contents reload while reset is high.
  logic [DATA_W-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        mem_rdata         <= ~mem_wdata;
      end else begin
        mem_rdata <= env_mem[mem_addr];
      end
    end
  end

  // Reference model state: what each requester should see next cycle.
  int          checks = 0;
  int          errors = 0;
  int          streak = 0;
  bit          p_if, p_dm, p_err;
  logic [31:0] p_data;
  logic [31:0] ref_mem [DEPTH];
  bit          last_ia, last_da;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, compare, advance the model.
  task automatic cycle(input bit rst, input bit ireq, input logic [31:0] iaddr,
                       input bit dreq, input bit dwe, input logic [31:0] daddr,
                       input logic [31:0] wdata);
    bit          g_if, g_dm, inr, store, e_if_v, e_dm_v;
    logic [31:0] a;
    int          w;
    @(negedge clk);
    reset = rst; if_req = ireq; if_addr = iaddr;
    dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_wdata = wdata;
    #1;
    // responses owed from the previous cycle
    e_if_v = !rst && p_if;
    e_dm_v = !rst && p_dm;
    check("if_valid", if_valid, e_if_v);
    check("dm_valid", dm_valid, e_dm_v);
    check("if_rdata", if_rdata, e_if_v ? p_data : 32'h0);
    check("dm_rdata", dm_rdata, e_dm_v ? p_data : 32'h0);
    check("if_err",   if_err,   e_if_v && p_err);
    check("dm_err",   dm_err,   e_dm_v && p_err);
    // this cycle's grant
    g_dm  = !rst && dreq && !(ireq && streak == STARVE_MAX);
    g_if  = !rst && ireq && !g_dm;
    a     = g_dm ? daddr : iaddr;
    inr   = (a < 32'(4 * DEPTH)) && (a % 4 == 0);
    w     = int'(a / 4) % DEPTH;
    store = g_dm && dwe;
    check("if_ack", if_ack, g_if);
    check("dm_ack", dm_ack, g_dm);
    check("mem_en", mem_en, (g_if || g_dm) && inr);
    if ((g_if || g_dm) && inr) begin
      check("mem_addr", mem_addr, w);
      check("mem_we",   mem_we,   store);
      if (store) check("mem_wdata", mem_wdata, wdata);
    end
    last_ia = if_ack;
    last_da = dm_ack;
    @(posedge clk);
    if (rst) begin
      p_if = 0; p_dm = 0; p_err = 0; p_data = 0; streak = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    end else begin
      p_if   = g_if;
      p_dm   = g_dm;
      p_err  = !inr;
      p_data = ((g_if || g_dm) && inr && !store) ? ref_mem[w] : 32'h0;
      if (store && inr) ref_mem[w] = wdata;
      streak = (ireq && !g_if) ? ((streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1) : 0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return r;
      1:       return {25'h0, r[4:0], r[6:5] | 2'b01};
      default: return {25'h0, r[4:0], 2'b00};
    endcase
  endfunction

  bit          starve_if [6];
  bit          starve_dm [6];
  bit          ir, dr, dw, rs;
  logic [31:0] ia, da, wd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;

    // reset dominates live requests
    cycle(1, 1, 32'h8, 1, 1, 32'h10, 32'h1234);
    cycle(1, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    check("rst_starve_cnt", dut.starve_cnt, 0);

    // fetch only
    cycle(0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    #1;
    check("fetch_valid", if_valid, 1);
    check("fetch_rdata", if_rdata, 32'h2008_0005);
    check("fetch_dm_quiet", dm_valid, 0);

    // store then load
    cycle(0, 0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("store_valid", dm_valid, 1);
    check("store_rdata", dm_rdata, 32'h0);
    cycle(0, 0, 32'h0, 1, 0, 32'h10, 32'h0);
    #1;
    check("load_rdata", dm_rdata, 32'hDEAD_BEEF);
    idle();

    // contention: fetch held, data re-requesting every cycle
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 32'h0C, 1, 0, 32'h14, 32'h0);
      starve_if[k] = last_ia;
      starve_dm[k] = last_da;
      if (k == 4) begin
        #1;
        check("starve_cleared", dut.starve_cnt, 0);
      end
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("starve_if_ack%0d", k), starve_if[k], k == 4);
      check($sformatf("starve_dm_ack%0d", k), starve_dm[k], k != 4);
    end
    idle();

    // out-of-range accesses
    cycle(0, 0, 32'h0, 1, 0, 32'h80, 32'h0);
    #1;
    check("oor_dm_err",   dm_err,   1);
    check("oor_dm_rdata", dm_rdata, 32'h0);
    cycle(0, 1, 32'h6, 0, 0, 32'h0, 32'h0);
    #1;
    check("oor_if_valid", if_valid, 1);
    check("oor_if_err",   if_err,   1);
    check("oor_if_rdata", if_rdata, 32'h0);

    // reset right after a fetch grant discards the response
    cycle(0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    check("midrst_if_valid", if_valid, 0);
    check("midrst_starve", dut.starve_cnt, 0);
    idle();
    cycle(0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    #1;
    check("post_rst_fetch", if_rdata, 32'h2008_0005);

    // fetch cancelled while losing to data
    idle();
    cycle(0, 1, 32'h4, 1, 0, 32'h18, 32'h0);
    cycle(0, 1, 32'h4, 1, 0, 32'h18, 32'h0);
    cycle(0, 0, 32'h4, 1, 0, 32'h18, 32'h0);
    check("cancel_no_ack", last_ia, 0);
    #1;
    check("cancel_starve", dut.starve_cnt, 0);
    idle();
    idle();

    // randomized traffic obeying the hold-until-ack contract
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; wd = 0;
    repeat (500) begin
      if (!ir && $urandom_range(0, 2) != 0) begin
        ir = 1; ia = rand_addr();
      end else if (ir && $urandom_range(0, 15) == 0) begin
        ir = 0;
      end
      if (!dr && $urandom_range(0, 3) != 0) begin
        dr = 1; da = rand_addr(); dw = $urandom_range(0, 1) == 1; wd = $urandom;
      end else if (dr && $urandom_range(0, 15) == 0) begin
        dr = 0;
      end
      rs = $urandom_range(0, 99) == 0;
      cycle(rs, ir, ia, dr, dw, da, wd);
      if (last_ia) ir = 0;
      if (last_da) dr = 0;
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
